// File: rtl/pipeline_stall_ctrl_if.sv
// ID-stage hazard bus between the decoder and the stall controller.
// The master side is the decoder/IF/memory; the slave side is the controller.
interface pipeline_stall_ctrl_if;
  logic [6:0] opc_id;
  logic       id_valid;
  logic [4:0] rd_id;
  logic [4:0] rs1_if;
  logic [4:0] rs2_if;
  logic       mem_busy;
  logic       flush;
  logic       stall_en;
  logic       pc_en;
  logic       busy;
  logic [1:0] state;

  modport master (
    output opc_id, id_valid, rd_id, rs1_if, rs2_if, mem_busy, flush,
    input  stall_en, pc_en, busy, state
  );

  modport slave (
    input  opc_id, id_valid, rd_id, rs1_if, rs2_if, mem_busy, flush,
    output stall_en, pc_en, busy, state
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Bubble/PC-hold penalty counter for control transfers and load-use hazards.
// Outputs depend only on registered state and mem_busy.
module pipeline_stall_ctrl #(
  parameter int CNT_W           = 3,
  parameter int CTRL_NOPS       = 3,
  parameter int CTRL_HOLD       = 2,
  parameter int LOAD_NOPS       = 1,
  parameter int LOAD_HOLD       = 1,
  parameter int LOAD_USE_DETECT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [CNT_W-1:0] C_NOPS = CNT_W'(CTRL_NOPS);
  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(CTRL_HOLD);
  localparam logic [CNT_W-1:0] L_NOPS = CNT_W'(LOAD_NOPS);
  localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(LOAD_HOLD);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, CTRL = 2'd1, LOAD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] nop_q, nop_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic is_ctrl, is_load, ld_dep, ctrl_trig, load_trig;

  assign is_ctrl = (bus.opc_id == OPC_JAL) || (bus.opc_id == OPC_JALR) ||
                   (bus.opc_id == OPC_BRANCH);
  assign is_load = (bus.opc_id == OPC_LOAD);
  // x0 never carries a dependency, so a load into x0 cannot cause a hazard.
  assign ld_dep  = (bus.rd_id != 5'd0) &&
                   ((bus.rd_id == bus.rs1_if) || (bus.rd_id == bus.rs2_if));

  assign ctrl_trig = bus.id_valid && is_ctrl;
  assign load_trig = bus.id_valid && is_load && ((LOAD_USE_DETECT == 0) || ld_dep);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      nop_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      nop_q   <= nop_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nop_d   = nop_q;
    hold_d  = hold_q;
    if (bus.flush) begin
      state_d = IDLE;
      nop_d   = '0;
      hold_d  = '0;
    end else if (!bus.mem_busy) begin
      case (state_q)
        IDLE: begin
          if (ctrl_trig) begin
            state_d = CTRL;
            nop_d   = C_NOPS;
            hold_d  = C_HOLD;
          end else if (load_trig) begin
            state_d = LOAD;
            nop_d   = L_NOPS;
            hold_d  = L_HOLD;
          end
        end
        CTRL, LOAD: begin
          // ID holds bubbles during a penalty, so opc_id is not looked at here.
          nop_d  = (nop_q  != '0) ? nop_q  - ONE : '0;
          hold_d = (hold_q != '0) ? hold_q - ONE : '0;
          if (nop_d == '0) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          nop_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign bus.stall_en = (nop_q != '0) && !bus.mem_busy;
  assign bus.pc_en    = (hold_q == '0) && !bus.mem_busy;
  assign bus.busy     = (state_q != IDLE);
  assign bus.state    = state_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scenarios with a cycle-tagged expectation queue drained by a monitor.
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc_n = 0;
  int   vecs  = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;

  // expected vector = {stall_en, pc_en, busy, state[1:0]}
  localparam logic [4:0] IDLE_V = 5'b01000;
  localparam logic [4:0] RST_MB = 5'b00000;
  localparam logic [4:0] C_HLD  = 5'b10101;
  localparam logic [4:0] C_REL  = 5'b11101;
  localparam logic [4:0] C_FRZ  = 5'b00101;
  localparam logic [4:0] L_HLD  = 5'b10110;

  pipeline_stall_ctrl_if ifa ();
  pipeline_stall_ctrl_if ifb ();
  pipeline_stall_ctrl_if ifc ();

  pipeline_stall_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipeline_stall_ctrl #(.CTRL_NOPS(5), .CTRL_HOLD(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  pipeline_stall_ctrl #(.LOAD_USE_DETECT(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  typedef struct {
    int         cyc;
    int         dut;
    logic [4:0] v;
    string      name;
  } exp_t;
  exp_t q[$];

  function automatic logic [4:0] obs(input int d);
    case (d)
      0:       return {ifa.stall_en, ifa.pc_en, ifa.busy, ifa.state};
      1:       return {ifb.stall_en, ifb.pc_en, ifb.busy, ifb.state};
      default: return {ifc.stall_en, ifc.pc_en, ifc.busy, ifc.state};
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  initial begin
    exp_t e;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc_n) begin
        e = q.pop_front();
        got = obs(e.dut);
        vecs++;
        if (e.cyc < cyc_n) begin
          fails++;
          $display("FAIL %s: stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc_n);
        end else if (got !== e.v) begin
          fails++;
          $display("FAIL %s dut%0d cyc=%0d: got {stall,pc,busy,st}=%b want %b",
                   e.name, e.dut, cyc_n, got, e.v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [6:0] o, input logic v, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic m, input logic f);
    ifa.opc_id = o; ifa.id_valid = v; ifa.rd_id = d; ifa.rs1_if = s1; ifa.rs2_if = s2;
    ifa.mem_busy = m; ifa.flush = f;
    ifb.opc_id = o; ifb.id_valid = v; ifb.rd_id = d; ifb.rs1_if = s1; ifb.rs2_if = s2;
    ifb.mem_busy = m; ifb.flush = f;
    ifc.opc_id = o; ifc.id_valid = v; ifc.rd_id = d; ifc.rs1_if = s1; ifc.rs2_if = s2;
    ifc.mem_busy = m; ifc.flush = f;
  endtask

  task automatic nop();
    drv(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input int d, input logic [4:0] v, input string n);
    exp_t e;
    e.cyc = cyc_n; e.dut = d; e.v = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; nop();
    tick(); rst = 1'b0; nop();
  endtask

  initial begin
    rst = 1'b1;
    nop();
    // reset state
    tick(); chk(0, IDLE_V, "rst_idle");
    tick(); drv(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); chk(0, RST_MB, "rst_membusy");
    tick(); rst = 1'b0; nop(); chk(0, IDLE_V, "post_rst");

    // control trigger, defaults
    tick(); drv(BRANCH, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); chk(0, IDLE_V, "br_T");
    tick(); nop(); chk(0, C_HLD,  "br_T1");
    tick(); nop(); chk(0, C_HLD,  "br_T2");
    tick(); nop(); chk(0, C_REL,  "br_T3");
    tick(); nop(); chk(0, IDLE_V, "br_T4");

    // id_valid=0 and flush-with-trigger are both ignored
    tick(); drv(BRANCH, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, IDLE_V, "inv_T");
    tick(); drv(JAL, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk(0, IDLE_V, "inv_T1");
    tick(); nop(); chk(0, IDLE_V, "flush_trig_T1");

    // load-use qualification
    tick(); drv(LOAD, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0); chk(0, IDLE_V, "ld_T");
    tick(); nop(); chk(0, L_HLD,  "ld_dep_T1");
    tick(); nop(); chk(0, IDLE_V, "ld_dep_T2");
    tick(); drv(LOAD, 1'b1, 5'd5, 5'd6, 5'd6, 1'b0, 1'b0);
    tick(); nop(); chk(0, IDLE_V, "ld_nodep_T1");
    tick(); drv(LOAD, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    tick(); nop(); chk(0, IDLE_V, "ld_x0_T1");

    // memory freeze stretches the penalty
    tick(); drv(JAL, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, IDLE_V, "mb_T");
    tick(); nop(); chk(0, C_HLD, "mb_T1");
    tick(); drv(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); chk(0, C_FRZ, "mb_T2");
    tick(); drv(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); chk(0, C_FRZ, "mb_T3");
    tick(); nop(); chk(0, C_HLD,  "mb_T4");
    tick(); nop(); chk(0, C_REL,  "mb_T5");
    tick(); nop(); chk(0, IDLE_V, "mb_T6");

    // flush, re-trigger, masking during CTRL, back-to-back
    tick(); drv(JALR, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, IDLE_V, "fl_T");
    tick(); drv(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk(0, C_HLD, "fl_T1");
    tick(); drv(BRANCH, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, IDLE_V, "fl_T2");
    tick(); drv(BRANCH, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, C_HLD, "acc_T3");
    tick(); drv(BRANCH, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, C_HLD, "mask_T4");
    tick(); drv(BRANCH, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, C_REL, "mask_T5");
    tick(); drv(BRANCH, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk(0, IDLE_V, "b2b_T6");
    tick(); nop(); chk(0, C_HLD,  "b2b_T7");
    tick(); nop(); chk(0, C_HLD,  "b2b_T8");
    tick(); nop(); chk(0, C_REL,  "b2b_T9");
    tick(); nop(); chk(0, IDLE_V, "b2b_T10");

    // async reset mid-penalty; sampled before the next rising edge
    do_reset();
    tick(); drv(BRANCH, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); nop(); chk(0, C_HLD, "ar_T1");
    tick(); rst = 1'b1; chk(0, IDLE_V, "ar_a_T2"); chk(1, IDLE_V, "ar_b_T2");
    tick(); rst = 1'b0; chk(0, IDLE_V, "ar_T3");

    // CTRL_NOPS=5, CTRL_HOLD=4
    tick(); drv(BRANCH, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk(1, IDLE_V, "p_T");
    tick(); nop(); chk(1, C_HLD,  "p_T1");
    tick(); nop(); chk(1, C_HLD,  "p_T2");
    tick(); nop(); chk(1, C_HLD,  "p_T3");
    tick(); nop(); chk(1, C_HLD,  "p_T4");
    tick(); nop(); chk(1, C_REL,  "p_T5");
    tick(); nop(); chk(1, IDLE_V, "p_T6");

    // LOAD_USE_DETECT=0 stalls on unrelated registers; default DUT does not
    do_reset();
    tick(); drv(LOAD, 1'b1, 5'd3, 5'd7, 5'd8, 1'b0, 1'b0); chk(2, IDLE_V, "nd_T");
    tick(); nop(); chk(2, L_HLD, "nd_c_T1"); chk(0, IDLE_V, "nd_a_T1");
    tick(); nop(); chk(2, IDLE_V, "nd_T2");

    repeat (3) tick();
    if (q.size() != 0) begin
      vecs++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
